// File: rtl/msu_pkg.sv
// Shared types and constants for the MSU memory-side read responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package msu_pkg;

    localparam int MSU_WORD_W    = 64;
    localparam int MSU_BURST_LEN = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FILL  = 2'd2
    } msu_state_e;

    // Index width of a line; a 2-word line still needs one index bit.
    function automatic int msu_idx_w(input int burst_len);
        return (burst_len > 2) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/msu_line_buf.sv
// One-line burst buffer: DEPTH x 64-bit words, synchronous write, combinational read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; writes are accepted every cycle we is high.
module msu_line_buf
    import msu_pkg::*;
#(
    parameter int DEPTH = MSU_BURST_LEN,
    parameter int IDX_W = 2
) (
    input  logic                  clk_sys,
    input  logic                  we,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [MSU_WORD_W-1:0] wr_dat,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [MSU_WORD_W-1:0] rd_dat
);

    logic [MSU_WORD_W-1:0] mem_q [DEPTH];
    logic [MSU_WORD_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[wr_idx] = wr_dat;
        end
    end

    // Contents are qualified by line_valid in the responder, so no reset here.
    always_ff @(posedge clk_sys) begin
        mem_q <= mem_d;
    end

    assign rd_dat = mem_q[rd_idx];

endmodule

// File: rtl/msu_ram_responder.sv
// Memory side of the MSU toggle req/ack read channel, backed by a one-line burst buffer.
// Latency: hit acks 1 cycle after req is seen; miss acks 1 cycle after the critical beat.
// Backpressure: holds mem_rd/mem_addr while mem_waitrequest; client waits while req != ack.
module msu_ram_responder
    import msu_pkg::*;
#(
    parameter int BURST_LEN = MSU_BURST_LEN,
    parameter int ADDR_W    = 29
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  req,
    output logic                  ack,
    output logic [MSU_WORD_W-1:0] req_dout,
    input  logic                  flush,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [7:0]            mem_burstcnt,
    output logic                  mem_rd,
    input  logic                  mem_waitrequest,
    input  logic [MSU_WORD_W-1:0] mem_rdata,
    input  logic                  mem_rdvalid
);

    localparam int               IDX_W     = msu_idx_w(BURST_LEN);
    localparam int               TAG_W     = ADDR_W - IDX_W;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BURST_LEN - 1);

    msu_state_e            state_q, state_d;
    logic                  ack_q, ack_d;
    logic [MSU_WORD_W-1:0] dout_q, dout_d;
    logic                  mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic                  line_valid_q, line_valid_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [ADDR_W-1:0]     cur_addr_q, cur_addr_d;
    logic [IDX_W-1:0]      beat_q, beat_d;

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      cur_tag;
    logic [IDX_W-1:0]      cur_idx;
    logic                  pending;
    logic                  hit;
    logic                  buf_we;
    logic [MSU_WORD_W-1:0] buf_rd_dat;

    assign req_tag = req_addr[ADDR_W-1:IDX_W];
    assign req_idx = req_addr[IDX_W-1:0];
    assign cur_tag = cur_addr_q[ADDR_W-1:IDX_W];
    assign cur_idx = cur_addr_q[IDX_W-1:0];
    assign pending = (req != ack_q);
    // A flush arriving with the request forces a refill rather than serving stale data.
    assign hit     = line_valid_q && (tag_q == req_tag) && !flush;

    msu_line_buf #(
        .DEPTH (BURST_LEN),
        .IDX_W (IDX_W)
    ) u_line_buf (
        .clk_sys (clk_sys),
        .we      (buf_we),
        .wr_idx  (beat_q),
        .wr_dat  (mem_rdata),
        .rd_idx  (req_idx),
        .rd_dat  (buf_rd_dat)
    );

    always_comb begin
        state_d      = state_q;
        ack_d        = ack_q;
        dout_d       = dout_q;
        mem_rd_d     = mem_rd_q;
        mem_addr_d   = mem_addr_q;
        line_valid_d = line_valid_q;
        flush_pend_d = flush_pend_q;
        tag_d        = tag_q;
        cur_addr_d   = cur_addr_q;
        beat_d       = beat_q;
        buf_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    line_valid_d = 1'b0;
                end
                if (pending) begin
                    cur_addr_d = req_addr;
                    if (hit) begin
                        dout_d = buf_rd_dat;
                        ack_d  = req;
                    end else begin
                        mem_addr_d   = {req_tag, {IDX_W{1'b0}}};
                        mem_rd_d     = 1'b1;
                        line_valid_d = 1'b0;
                        state_d      = ISSUE;
                    end
                end
            end

            ISSUE: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (!mem_waitrequest) begin
                    mem_rd_d = 1'b0;
                    beat_d   = '0;
                    state_d  = FILL;
                end
            end

            FILL: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_rdvalid) begin
                    buf_we = 1'b1;
                    beat_d = beat_q + 1'b1;
                    // Critical word first: the client is released as soon as its beat lands.
                    if (beat_q == cur_idx) begin
                        dout_d = mem_rdata;
                        ack_d  = req;
                    end
                    if (beat_q == LAST_BEAT) begin
                        tag_d        = cur_tag;
                        line_valid_d = ~(flush_pend_q | flush);
                        flush_pend_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ack_q        <= 1'b0;
            dout_q       <= '0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            line_valid_q <= 1'b0;
            flush_pend_q <= 1'b0;
            tag_q        <= '0;
            cur_addr_q   <= '0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            dout_q       <= dout_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
            line_valid_q <= line_valid_d;
            flush_pend_q <= flush_pend_d;
            tag_q        <= tag_d;
            cur_addr_q   <= cur_addr_d;
            beat_q       <= beat_d;
        end
    end

    assign ack          = ack_q;
    assign req_dout     = dout_q;
    assign mem_rd       = mem_rd_q;
    assign mem_addr     = mem_addr_q;
    assign mem_burstcnt = 8'(BURST_LEN);

endmodule

// File: tb/tb_msu_ram_responder.sv
// Directed bench for msu_ram_responder: hits, misses, stalls, flushes and mid-burst reset.
// Memory data for word address a is {8'hD0, 27'h0, a}.
module tb_msu_ram_responder;

    localparam int AW = 29;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic [AW-1:0] req_addr;
    logic          req;
    logic          ack;
    logic [63:0]   req_dout;
    logic          flush;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_burstcnt;
    logic          mem_rd;
    logic          mem_waitrequest;
    logic [63:0]   mem_rdata;
    logic          mem_rdvalid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_sys = ~clk_sys;

    msu_ram_responder #(
        .BURST_LEN (4),
        .ADDR_W    (AW)
    ) dut (
        .clk_sys         (clk_sys),
        .reset_n         (reset_n),
        .req_addr        (req_addr),
        .req             (req),
        .ack             (ack),
        .req_dout        (req_dout),
        .flush           (flush),
        .mem_addr        (mem_addr),
        .mem_burstcnt    (mem_burstcnt),
        .mem_rd          (mem_rd),
        .mem_waitrequest (mem_waitrequest),
        .mem_rdata       (mem_rdata),
        .mem_rdvalid     (mem_rdvalid)
    );

    function automatic logic [63:0] dat(input logic [AW-1:0] a);
        return {8'hD0, 27'h0, a};
    endfunction

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Toggle req (optionally with flush in the same cycle) and let one edge pass.
    task automatic request(input logic [AW-1:0] a, input logic with_flush);
        req_addr = a;
        req      = ~req;
        flush    = with_flush;
        tick;
        flush    = 1'b0;
    endtask

    task automatic expect_hit(input string tag, input logic [AW-1:0] a);
        request(a, 1'b0);
        chk({tag, "_ack"}, ack, req);
        chk({tag, "_dat"}, req_dout, dat(a));
        chk({tag, "_nord"}, mem_rd, 1'b0);
    endtask

    task automatic expect_miss(input string tag, input logic [AW-1:0] line);
        chk({tag, "_rd"}, mem_rd, 1'b1);
        chk({tag, "_addr"}, mem_addr, line);
        chk({tag, "_pend"}, ack, !req);
    endtask

    // Hold waitrequest for 'stalls' cycles, then accept the read.
    task automatic issue(input logic [AW-1:0] line, input int stalls);
        for (int i = 0; i < stalls; i++) begin
            mem_waitrequest = 1'b1;
            chk("stall_rd", mem_rd, 1'b1);
            chk("stall_addr", mem_addr, line);
            tick;
        end
        chk("issue_rd", mem_rd, 1'b1);
        chk("issue_addr", mem_addr, line);
        mem_waitrequest = 1'b0;
        tick;
        chk("issue_done", mem_rd, 1'b0);
    endtask

    task automatic fill(input logic [AW-1:0] line, input int crit, input int flush_at);
        for (int b = 0; b < 4; b++) begin
            mem_rdvalid = 1'b1;
            mem_rdata   = dat(line + AW'(b));
            flush       = (b == flush_at);
            tick;
            mem_rdvalid = 1'b0;
            mem_rdata   = '0;
            flush       = 1'b0;
            chk("fill_nord", mem_rd, 1'b0);
            if (b < crit) begin
                chk("fill_pend", ack, !req);
            end else if (b == crit) begin
                chk("crit_ack", ack, req);
                chk("crit_dat", req_dout, dat(line + AW'(crit)));
            end
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        req             = 1'b1;
        req_addr        = 29'h0000105;
        flush           = 1'b0;
        mem_waitrequest = 1'b0;
        mem_rdata       = '0;
        mem_rdvalid     = 1'b0;

        tick;
        tick;
        tick;
        chk("rst_ack", ack, 1'b0);
        chk("rst_rd", mem_rd, 1'b0);
        chk("rst_dout", req_dout, 64'h0);
        chk("rst_addr", mem_addr, 29'h0);

        // Request was already pending through reset: cold miss on release.
        reset_n = 1'b1;
        tick;
        expect_miss("cold", 29'h0000104);
        chk("burstcnt", mem_burstcnt, 8'd4);
        issue(29'h0000104, 0);
        fill(29'h0000104, 1, -1);

        expect_hit("hit106", 29'h0000106);
        expect_hit("hit104", 29'h0000104);

        // Stalled issue: one burst only, address held throughout.
        request(29'h0000200, 1'b0);
        expect_miss("stall", 29'h0000200);
        issue(29'h0000200, 5);
        fill(29'h0000200, 0, -1);
        tick;
        chk("one_burst_a", mem_rd, 1'b0);
        tick;
        chk("one_burst_b", mem_rd, 1'b0);
        expect_hit("hit203", 29'h0000203);

        // Flush at beat 2, critical word is beat 3: data still correct, line dropped.
        request(29'h0000107, 1'b0);
        expect_miss("fl_fill", 29'h0000104);
        issue(29'h0000104, 0);
        fill(29'h0000104, 3, 2);
        request(29'h0000104, 1'b0);
        expect_miss("after_fl", 29'h0000104);
        issue(29'h0000104, 0);
        fill(29'h0000104, 0, -1);

        // Flush in IDLE alongside a would-be hit turns it into a miss.
        request(29'h0000105, 1'b1);
        expect_miss("fl_idle", 29'h0000104);
        issue(29'h0000104, 0);
        fill(29'h0000104, 1, -1);
        expect_hit("hit105", 29'h0000105);

        // Top line of the address space.
        request(29'h1FFFFFFF, 1'b0);
        expect_miss("top", 29'h1FFFFFFC);
        issue(29'h1FFFFFFC, 0);
        fill(29'h1FFFFFFC, 3, -1);
        expect_hit("hit_top", 29'h1FFFFFFD);

        // Reset two beats into a fill; stray beats afterwards are ignored.
        request(29'h0000302, 1'b0);
        expect_miss("mid", 29'h0000300);
        issue(29'h0000300, 0);
        for (int b = 0; b < 2; b++) begin
            mem_rdvalid = 1'b1;
            mem_rdata   = dat(29'h0000300 + AW'(b));
            tick;
        end
        mem_rdvalid = 1'b0;
        reset_n     = 1'b0;
        req         = 1'b0;
        tick;
        reset_n = 1'b1;
        chk("mrst_ack", ack, 1'b0);
        chk("mrst_rd", mem_rd, 1'b0);
        chk("mrst_dout", req_dout, 64'h0);
        for (int b = 0; b < 2; b++) begin
            mem_rdvalid = 1'b1;
            mem_rdata   = 64'hBAD0_BAD0_BAD0_BAD0;
            tick;
            chk("stray_rd", mem_rd, 1'b0);
            chk("stray_ack", ack, 1'b0);
        end
        mem_rdvalid = 1'b0;
        mem_rdata   = '0;
        request(29'h0000302, 1'b0);
        expect_miss("fresh", 29'h0000300);
        issue(29'h0000300, 0);
        fill(29'h0000300, 2, -1);
        expect_hit("hit301", 29'h0000301);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/msu_ram_responder.md
Name: msu_ram_responder

Overview:
- Memory-side end of the MSU toggle req/ack read channel.
- Accepts 64-bit word read requests from the MSU data-store client (req toggles, done when ack == req).
- Services requests from a one-line burst buffer, or fills that buffer with an aligned Avalon-MM burst read from SDRAM/DDR.
- Sits between the MSU client and the system memory arbiter port.

Parameters:
BURST_LEN, 4, words per line and per burst; power of two, 2..16.
ADDR_W, 29, word address width (byte address bits [31:3]).

Ports:
clk_sys  in  1  system clock
reset_n  in  1  synchronous reset, active low
req_addr  in  ADDR_W  word address; stable while req != ack
req  in  1  request toggle from client
ack  out  1  acknowledge toggle; equals req when idle/done
req_dout  out  64  read data; valid when ack == req
flush  in  1  level/pulse; invalidates line buffer
mem_addr  out  ADDR_W  burst start word address (line-aligned)
mem_burstcnt  out  8  burst length, constant BURST_LEN
mem_rd  out  1  Avalon read strobe
mem_waitrequest  in  1  Avalon stall
mem_rdata  in  64  Avalon read data
mem_rdvalid  in  1  Avalon read data valid

Behaviour:
- Reset (reset_n low at edge): ack=0, req_dout=0, mem_rd=0, mem_addr=0, line_valid=0, flush_pend=0, state=IDLE. Applies mid-operation; any burst in flight is abandoned.
- Pending request = (req != ack), compared as levels, evaluated only in IDLE; req_addr latched into cur_addr on acceptance.
- IDX_W = log2(BURST_LEN); tag = addr[ADDR_W-1:IDX_W]; idx = addr[IDX_W-1:0].
- IDLE, pending, line_valid, tag match, no flush this cycle (hit):
  - req_dout <= line[idx]; ack <= req.
  - Ack visible one cycle after the request is observed.
  - Stay in IDLE.
- IDLE, pending, otherwise (miss):
  - mem_addr <= {tag, IDX_W'b0}; mem_rd <= 1; line_valid <= 0.
  - state <= ISSUE.
- ISSUE: mem_rd and mem_addr held until a cycle with mem_waitrequest=0. At that edge mem_rd <= 0, beat counter <= 0, state <= FILL.
- FILL: each mem_rdvalid cycle:
  - Writes line[beat] = mem_rdata; beat++.
  - Critical word: when beat == idx of cur_addr, req_dout <= mem_rdata and ack <= req in the same edge (ack one cycle after the beat).
  - After beat BURST_LEN-1: tag <= cur tag; line_valid <= ~(flush_pend | flush); flush_pend <= 0; state <= IDLE.
- Requests during FILL (after the early ack) stay pending and are evaluated in IDLE after fill completes.
- flush:
  - In IDLE: clears line_valid at that edge; a simultaneous request is treated as a miss.
  - In ISSUE/FILL: sets flush_pend; the current ack is still delivered with correct data.
- mem_rdvalid outside FILL is ignored. The memory controller shares reset_n, so no drain state.
- Address arithmetic is unsigned, ADDR_W wide. Bursts are line-aligned and never wrap; the top line (0x1FFFFFFC..0x1FFFFFFF for BURST_LEN=4) is legal.
- Only one burst is outstanding at a time; mem_burstcnt = BURST_LEN always.

Decomposition:
- Package msu_pkg: state enum (IDLE, ISSUE, FILL), MSU_WORD_W=64, default BURST_LEN, IDX_W derivation function.
- Sub-module msu_line_buf: BURST_LEN x 64 register array, one synchronous write port (beat, data, we) and one combinational read port (idx).

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with req=1 -> ack=0, mem_rd=0, req_dout=0. On release, request pending (req=1 != ack=0) -> miss burst issued.
- Cold miss, req_addr=0x0000105, BURST_LEN=4:
  - mem_addr=0x0000104, burstcnt=4, one mem_rd cycle with waitrequest=0.
  - Beats D0..D3: ack toggles the cycle after D1 with req_dout=D1.
  - Back to IDLE after D3.
- Hit after that fill, req_addr=0x0000106: no mem_rd; ack toggles the next cycle; req_dout=D2.
- Stall: mem_waitrequest=1 for 5 cycles -> mem_rd=1 and mem_addr stable for 6 cycles; exactly one burst accepted.
- Flush during FILL (pulse at beat 2): ack delivered with correct data; following req 0x0000104 -> new burst at 0x0000104.
- Reset after 2 beats of FILL: ack=0, mem_rd=0; 2 stray rdvalid beats ignored; next request issues a fresh burst and returns correct data.
